shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller for the team's 4-bit universal shift register (mode pins s1/s0, serial MSB_in/LSB_in, parallel I_par, output A_par).
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right N, shift left N, or rotate right N.
- Drives the register's mode and serial pins for exactly the required number of clock edges, then pulses done.
- Sits between a host/test FSM and the register. The register shares this block's clk and clear_b.

Parameters:
WIDTH, 4, width of the controlled register and of cmd_data/I_par/A_par
CNT_W, 3, width of cmd_count; max shift count 2**CNT_W-1

Ports:
clk  input  1  rising-edge clock, shared with the shift register
clear_b  input  1  asynchronous active-low reset, shared with the shift register
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROTR
cmd_data  input  WIDTH  parallel value for LOAD; ignored otherwise
cmd_count  input  CNT_W  number of shift edges for SHR/SHL/ROTR; ignored for LOAD
ser_in  input  1  serial fill bit for SHR/SHL, sampled live each shift cycle
A_par  input  WIDTH  current register contents (feedback for ROTR)
s1  output  1  register mode select, high bit
s0  output  1  register mode select, low bit
MSB_in  output  1  register right-shift serial input
LSB_in  output  1  register left-shift serial input
I_par  output  WIDTH  register parallel-load value
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. The state register, op register (2b), data register (WIDTH), and remaining-count register (CNT_W) reset asynchronously on clear_b low.
- Reset values: IDLE; op = 00; data = 0; count = 0. Outputs during and after reset: {s1,s0} = 00, I_par = 0, MSB_in = 0, LSB_in = 0, done = 0, busy = 0, cmd_ready = 1.
- Outputs are Moore-decoded from the registered state, op and data. No combinational path from cmd_* to s1/s0.
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. cmd_op, cmd_data and cmd_count are captured on that edge. cmd_valid while busy is ignored; the host must hold it.
- IDLE: {s1,s0} = 00.
  - Accept LOAD -> LOAD.
  - Accept SHR/SHL/ROTR with count != 0 -> SHIFT, with the remaining count set to cmd_count.
  - Accept SHR/SHL/ROTR with count == 0 -> DONE. No register change.
- LOAD (one cycle): {s1,s0} = 11, I_par = captured data. The next edge loads the register -> DONE.
- SHIFT: the remaining count decrements on each edge. At the edge where it is 1 -> DONE. Exactly cmd_count shift edges occur.
  - SHR: {s1,s0} = 01, MSB_in = ser_in.
  - SHL: {s1,s0} = 10, LSB_in = ser_in.
  - ROTR: {s1,s0} = 01, MSB_in = A_par[0].
  - Unused serial pin is driven 0.
- DONE (one cycle): {s1,s0} = 00, done = 1 -> IDLE. No new command is accepted in DONE.
- Latency, with accept edge E0:
  - Register updates on E1..EN (N = 1 for LOAD).
  - done is high in the cycle after EN.
  - cmd_ready returns high after edge EN+1.
  - busy/cmd_ready low for N+1 cycles; for count == 0, 1 cycle.
- I_par holds the last captured data in all states; the register only uses it in mode 11.
- Reset mid-operation: clear_b low forces IDLE immediately (asynchronously) and clears the register via the shared reset. No done pulse for the aborted command. The first command is accepted on the first edge after release.
- Back-to-back: cmd_valid held high through DONE is accepted on the edge leaving IDLE, one cycle after done.

Test Plan:
- Reset then idle: pulse clear_b low 2 cycles -> A_par = 0000, cmd_ready = 1, busy = 0, {s1,s0} = 00, done = 0.
- LOAD 1011 -> exactly one cycle of {s1,s0} = 11; A_par = 1011 after E1; done one cycle later; cmd_ready back after E2.
- From 1011: SHR count 2, ser_in = 1 -> A_par 1101 then 1110, one done pulse. Then SHL count 3 from loaded 1100, ser_in = 1 -> 1001, 0011, 0111.
- ROTR: from 1011, count 1 -> 1101; count 4 from 1011 -> 1011, with busy high 5 cycles. SHR count 0 -> done on the cycle after accept, A_par unchanged, no {s1,s0} != 00 cycle.
- Assert clear_b low at the 2nd edge of an SHR count 5 -> A_par = 0000, IDLE, no done. Then LOAD 1111 works normally.
- Hold cmd_valid high with two queued commands (LOAD 0110, then ROTR 2) -> second accepted one cycle after the first done; A_par ends 1001; cmd_valid during busy causes no extra action.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a 4-bit universal shift register: accepts LOAD/SHR/SHL/ROTR
// commands over valid/ready and drives the register's mode and serial pins.
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] A_par,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic [WIDTH-1:0] I_par,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Only the LSB of the register feeds back (rotate right); upper bits are unused.
  logic unused_a_par_hi;
  assign unused_a_par_hi = ^A_par[WIDTH-1:1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          count_d = cmd_count;
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd_count != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
      end
      ST_SHIFT: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Mode pins depend only on registered state/op; serial pins follow ser_in/A_par live.
  always_comb begin
    s1        = 1'b0;
    s0        = 1'b0;
    MSB_in    = 1'b0;
    LSB_in    = 1'b0;
    I_par     = data_q;
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE);
    done      = (state_q == ST_DONE);
    case (state_q)
      ST_LOAD: begin
        s1 = 1'b1;
        s0 = 1'b1;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SHR: begin
            s0     = 1'b1;
            MSB_in = ser_in;
          end
          OP_SHL: begin
            s1     = 1'b1;
            LSB_in = ser_in;
          end
          OP_ROTR: begin
            s0     = 1'b1;
            MSB_in = A_par[0];
          end
          default: begin
            s1 = 1'b0;
          end
        endcase
      end
      default: begin
        s1 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer driving a behavioural 4-bit universal
// shift register; expected register contents are hand-computed constants.
module tb_shift_reg_sequencer;

  logic       clk;
  logic       clear_b;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       ser_in;
  logic [3:0] A_par;
  logic       s1, s0, MSB_in, LSB_in;
  logic [3:0] I_par;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .clear_b   (clear_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .ser_in    (ser_in),
    .A_par     (A_par),
    .s1        (s1),
    .s0        (s0),
    .MSB_in    (MSB_in),
    .LSB_in    (LSB_in),
    .I_par     (I_par),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register: 00 hold, 01 shift right, 10 shift left, 11 load.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      A_par <= 4'b0000;
    end else begin
      case ({s1, s0})
        2'b01:   A_par <= {MSB_in, A_par[3:1]};
        2'b10:   A_par <= {A_par[2:0], LSB_in};
        2'b11:   A_par <= I_par;
        default: A_par <= A_par;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks mode pins, busy, ready (= !busy), done and register contents.
  task automatic chk_st(input string tag, input logic [1:0] exp_s, input logic exp_busy,
                        input logic exp_done, input logic [3:0] exp_a);
    chk({tag, ".mode"},  {6'b0, s1, s0},    {6'b0, exp_s});
    chk({tag, ".busy"},  {7'b0, busy},      {7'b0, exp_busy});
    chk({tag, ".ready"}, {7'b0, cmd_ready}, {7'b0, ~exp_busy});
    chk({tag, ".done"},  {7'b0, done},      {7'b0, exp_done});
    chk({tag, ".A"},     {4'b0, A_par},     {4'b0, exp_a});
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    clear_b   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    cmd_count = 3'd0;
    ser_in    = 1'b0;
    #1;
    chk_st("rst_in", 2'b00, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    clear_b = 1'b1;
    chk_st("rst_out", 2'b00, 1'b0, 1'b0, 4'b0000);
    chk("rst_ipar", {4'b0, I_par}, 8'h00);
    chk("rst_msb", {7'b0, MSB_in}, 8'h00);
    chk("rst_lsb", {7'b0, LSB_in}, 8'h00);

    // LOAD 1011
    issue(2'b00, 4'b1011, 3'd0);
    chk_st("ld_e0", 2'b11, 1'b1, 1'b0, 4'b0000);
    chk("ld_ipar", {4'b0, I_par}, 8'h0b);
    tick();
    chk_st("ld_e1", 2'b00, 1'b1, 1'b1, 4'b1011);
    tick();
    chk_st("ld_e2", 2'b00, 1'b0, 1'b0, 4'b1011);

    // SHR 2 with ser_in = 1
    ser_in = 1'b1;
    issue(2'b01, 4'b0000, 3'd2);
    chk_st("shr_e0", 2'b01, 1'b1, 1'b0, 4'b1011);
    chk("shr_msb", {7'b0, MSB_in}, 8'h01);
    chk("shr_lsb", {7'b0, LSB_in}, 8'h00);
    tick();
    chk_st("shr_e1", 2'b01, 1'b1, 1'b0, 4'b1101);
    tick();
    chk_st("shr_e2", 2'b00, 1'b1, 1'b1, 4'b1110);
    tick();
    chk_st("shr_e3", 2'b00, 1'b0, 1'b0, 4'b1110);

    // LOAD 1100 then SHL 3 with ser_in = 1
    issue(2'b00, 4'b1100, 3'd0);
    tick();
    tick();
    chk_st("shl_ld", 2'b00, 1'b0, 1'b0, 4'b1100);
    issue(2'b10, 4'b0000, 3'd3);
    chk_st("shl_e0", 2'b10, 1'b1, 1'b0, 4'b1100);
    chk("shl_lsb", {7'b0, LSB_in}, 8'h01);
    chk("shl_msb", {7'b0, MSB_in}, 8'h00);
    tick();
    chk_st("shl_e1", 2'b10, 1'b1, 1'b0, 4'b1001);
    tick();
    chk_st("shl_e2", 2'b10, 1'b1, 1'b0, 4'b0011);
    tick();
    chk_st("shl_e3", 2'b00, 1'b1, 1'b1, 4'b0111);
    tick();
    chk_st("shl_e4", 2'b00, 1'b0, 1'b0, 4'b0111);

    // ROTR 1 from 1011; ser_in = 0 shows the feedback comes from A_par[0]
    ser_in = 1'b0;
    issue(2'b00, 4'b1011, 3'd0);
    tick();
    tick();
    issue(2'b11, 4'b0000, 3'd1);
    chk_st("rot1_e0", 2'b01, 1'b1, 1'b0, 4'b1011);
    chk("rot1_msb", {7'b0, MSB_in}, 8'h01);
    tick();
    chk_st("rot1_e1", 2'b00, 1'b1, 1'b1, 4'b1101);
    tick();
    chk_st("rot1_e2", 2'b00, 1'b0, 1'b0, 4'b1101);

    // ROTR 4 from 1011: busy for 5 cycles, register returns to 1011
    issue(2'b00, 4'b1011, 3'd0);
    tick();
    tick();
    issue(2'b11, 4'b0000, 3'd4);
    chk_st("rot4_e0", 2'b01, 1'b1, 1'b0, 4'b1011);
    tick();
    chk_st("rot4_e1", 2'b01, 1'b1, 1'b0, 4'b1101);
    tick();
    chk_st("rot4_e2", 2'b01, 1'b1, 1'b0, 4'b1110);
    tick();
    chk_st("rot4_e3", 2'b01, 1'b1, 1'b0, 4'b0111);
    tick();
    chk_st("rot4_e4", 2'b00, 1'b1, 1'b1, 4'b1011);
    tick();
    chk_st("rot4_e5", 2'b00, 1'b0, 1'b0, 4'b1011);

    // SHR count 0: straight to DONE, no mode activity
    ser_in = 1'b1;
    issue(2'b01, 4'b0000, 3'd0);
    chk_st("shr0_e0", 2'b00, 1'b1, 1'b1, 4'b1011);
    tick();
    chk_st("shr0_e1", 2'b00, 1'b0, 1'b0, 4'b1011);

    // Reset during SHR 5 (ser_in = 0) after its first shift edge
    ser_in = 1'b0;
    issue(2'b01, 4'b0000, 3'd5);
    chk_st("abrt_e0", 2'b01, 1'b1, 1'b0, 4'b1011);
    tick();
    chk_st("abrt_e1", 2'b01, 1'b1, 1'b0, 4'b0101);
    clear_b = 1'b0;
    #1;
    chk_st("abrt_rst", 2'b00, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_st("abrt_c1", 2'b00, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_st("abrt_c2", 2'b00, 1'b0, 1'b0, 4'b0000);
    clear_b = 1'b1;
    issue(2'b00, 4'b1111, 3'd0);
    chk_st("ld15_e0", 2'b11, 1'b1, 1'b0, 4'b0000);
    tick();
    chk_st("ld15_e1", 2'b00, 1'b1, 1'b1, 4'b1111);
    tick();
    chk_st("ld15_e2", 2'b00, 1'b0, 1'b0, 4'b1111);

    // Back-to-back: LOAD 0110 then ROTR 2 with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0110;
    cmd_count = 3'd0;
    tick();
    cmd_op    = 2'b11;
    cmd_data  = 4'b0000;
    cmd_count = 3'd2;
    chk_st("b2b_e0", 2'b11, 1'b1, 1'b0, 4'b1111);
    tick();
    chk_st("b2b_e1", 2'b00, 1'b1, 1'b1, 4'b0110);
    tick();
    chk_st("b2b_e2", 2'b00, 1'b0, 1'b0, 4'b0110);
    tick();
    cmd_valid = 1'b0;
    chk_st("b2b_e3", 2'b01, 1'b1, 1'b0, 4'b0110);
    chk("b2b_msb", {7'b0, MSB_in}, 8'h00);
    tick();
    chk_st("b2b_e4", 2'b01, 1'b1, 1'b0, 4'b0011);
    tick();
    chk_st("b2b_e5", 2'b00, 1'b1, 1'b1, 4'b1001);
    tick();
    chk_st("b2b_e6", 2'b00, 1'b0, 1'b0, 4'b1001);
    tick();
    chk_st("b2b_e7", 2'b00, 1'b0, 1'b0, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
